// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives the DAC/track-hold around an
// analog comparator and resolves one result bit per settle+decide trial.
module sar_adc_ctrl #(
  parameter int NBITS      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic             wb_clk_i,
  input  logic             resetb,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic             cmp_en_o,
  output logic             sample_o,
  output logic [NBITS-1:0] dac_o,
  output logic             busy_o,
  output logic [NBITS-1:0] data_o,
  output logic             valid_o
);

  localparam int BPW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [7:0]       SAMPLE_LOAD = 8'(SAMPLE_CYC - 1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [NBITS-1:0] MSB_CODE    = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [BPW-1:0]   TOP_BIT     = BPW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, DECIDE, DONE} state_t;

  state_t           state_reg;
  logic [7:0]       cnt_reg;
  logic [BPW-1:0]   bitptr_reg;
  logic             cmp_meta_reg;
  logic             cmp_s_reg;
  logic [NBITS-1:0] bit_mask;
  logic [NBITS-1:0] decided;

  // cmp_i is asynchronous to wb_clk_i; only the synchronized copy is used.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      cmp_meta_reg <= 1'b0;
      cmp_s_reg    <= 1'b0;
    end else begin
      cmp_meta_reg <= cmp_i;
      cmp_s_reg    <= cmp_meta_reg;
    end
  end

  assign bit_mask = NBITS'(1) << bitptr_reg;
  assign decided  = cmp_s_reg ? dac_o : (dac_o & ~bit_mask);

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bitptr_reg <= '0;
      cmp_en_o   <= 1'b0;
      sample_o   <= 1'b0;
      dac_o      <= '0;
      busy_o     <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (abort_i && state_reg != IDLE) begin
        state_reg <= IDLE;
        dac_o     <= '0;
        sample_o  <= 1'b0;
        busy_o    <= 1'b0;
        cmp_en_o  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            // a simultaneous abort cancels the request
            if (start_i && !abort_i) begin
              state_reg <= SAMPLE;
              cnt_reg   <= SAMPLE_LOAD;
              sample_o  <= 1'b1;
              cmp_en_o  <= 1'b1;
              busy_o    <= 1'b1;
              dac_o     <= '0;
            end
          end
          SAMPLE: begin
            if (cnt_reg == 8'd0) begin
              state_reg  <= SETTLE;
              sample_o   <= 1'b0;
              dac_o      <= MSB_CODE;
              bitptr_reg <= TOP_BIT;
              cnt_reg    <= SETTLE_LOAD;
            end else begin
              cnt_reg <= cnt_reg - 8'd1;
            end
          end
          SETTLE: begin
            if (cnt_reg == 8'd0) begin
              state_reg <= DECIDE;
            end else begin
              cnt_reg <= cnt_reg - 8'd1;
            end
          end
          DECIDE: begin
            if (bitptr_reg != '0) begin
              dac_o      <= decided | (bit_mask >> 1);
              bitptr_reg <= bitptr_reg - BPW'(1);
              cnt_reg    <= SETTLE_LOAD;
              state_reg  <= SETTLE;
            end else begin
              dac_o     <= decided;
              state_reg <= DONE;
            end
          end
          DONE: begin
            data_o  <= dac_o;
            valid_o <= 1'b1;
            if (cont_i) begin
              state_reg <= SAMPLE;
              cnt_reg   <= SAMPLE_LOAD;
              sample_o  <= 1'b1;
              dac_o     <= '0;
            end else begin
              state_reg <= IDLE;
              busy_o    <= 1'b0;
              cmp_en_o  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_o    <= 1'b0;
            cmp_en_o  <= 1'b0;
            sample_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: comparator model closes the loop, a
// scoreboard holds expected results and the cycle each valid_o must appear.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start_i = 1'b0;
  logic       cont_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       cmp_i = 1'b0;
  logic       cmp_en_o, sample_o, busy_o, valid_o;
  logic [7:0] dac_o, data_o;
  logic [7:0] vin_code = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_seen = 0;
  int valid_exp = 0;
  int busy_cnt;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] trials [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  sar_adc_ctrl #(.NBITS(8), .SAMPLE_CYC(4), .SETTLE_CYC(4)) dut (
    .wb_clk_i (clk),
    .resetb   (resetb),
    .start_i  (start_i),
    .cont_i   (cont_i),
    .abort_i  (abort_i),
    .cmp_i    (cmp_i),
    .cmp_en_o (cmp_en_o),
    .sample_o (sample_o),
    .dac_o    (dac_o),
    .busy_o   (busy_o),
    .data_o   (data_o),
    .valid_o  (valid_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // comparator model with one cycle of analog skew
  always @(posedge clk) cmp_i <= (vin_code >= dac_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetb && valid_o) begin
      valid_seen++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid: got data 0x%0h at cycle %0d expected no valid", data_o, cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("txn %0d: data 0x%02h at cycle %0d (exp 0x%02h at %0d)", valid_seen, data_o, cyc, e.data, e.cyc);
        chk("result", data_o, e.data);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // returns just after the accept edge
  task automatic start_conv(input logic [7:0] vin, input bit expect_result);
    vin_code = vin;
    start_i  = 1'b1;
    if (expect_result) begin
      sb.push_back('{vin, cyc + 46});
      valid_exp++;
    end
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_dac", dac_o, 0);
    chk("rst_sample", sample_o, 0);
    chk("rst_cmp_en", cmp_en_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    resetb = 1'b1;
    tick();

    // single conversion with trial sequence and busy length
    start_conv(8'hA5, 1'b1);
    busy_cnt = 0;
    for (int j = 0; j < 50; j++) begin
      if (busy_o) busy_cnt++;
      if (j >= 6 && (j - 6) % 5 == 0 && (j - 6) / 5 < 8)
        chk($sformatf("dac_trial%0d", (j - 6) / 5), dac_o, trials[(j - 6) / 5]);
      tick();
    end
    chk("busy_cycles", busy_cnt, 45);
    wait_empty("single_done");

    // boundaries
    start_conv(8'h00, 1'b1);
    wait_empty("zero_done");
    start_conv(8'hFF, 1'b1);
    wait_empty("full_done");
    repeat (60) tick();
    chk("valid_count_bound", valid_seen, valid_exp);

    // continuous mode, input changed during the second sample phase
    cont_i = 1'b1;
    start_conv(8'h3C, 1'b1);
    sb.push_back('{8'hC3, cyc + 90});
    valid_exp++;
    for (int j = 0; j < 95; j++) begin
      if (j == 44) chk("sample_in_done", sample_o, 0);
      if (j == 45) chk("sample_reassert", sample_o, 1);
      if (j == 46) vin_code = 8'hC3;
      if (j == 60) cont_i = 1'b0;
      tick();
    end
    wait_empty("cont_done");
    repeat (10) tick();
    chk("cont_idle_busy", busy_o, 0);
    chk("valid_count_cont", valid_seen, valid_exp);

    // abort at clock 20 of a conversion
    start_conv(8'h5A, 1'b0);
    repeat (20) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_dac", dac_o, 0);
    chk("abort_sample", sample_o, 0);
    chk("abort_cmp_en", cmp_en_o, 0);
    chk("abort_data", data_o, 8'hC3);
    repeat (60) tick();
    chk("valid_count_abort", valid_seen, valid_exp);
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start_idle", busy_o, 0);
    start_conv(8'h5A, 1'b1);
    wait_empty("after_abort_done");

    // asynchronous reset during SETTLE
    start_conv(8'h77, 1'b0);
    repeat (10) tick();
    resetb = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_dac", dac_o, 0);
    chk("arst_sample", sample_o, 0);
    chk("arst_cmp_en", cmp_en_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_valid", valid_o, 0);
    repeat (3) @(posedge clk);
    #1;
    resetb = 1'b1;
    tick();
    start_conv(8'h96, 1'b1);
    repeat (10) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_empty("post_reset_done");
    repeat (60) tick();
    chk("valid_count_final", valid_seen, valid_exp);
    chk("final_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Digital successive-approximation controller that closes the loop around the on-chip analog comparator.
- Drives a binary-weighted DAC code onto the comparator's VINM side and a track/hold strobe for the VINP sample.
- Reads back the comparator's asynchronous VOUT through a 2-flop synchronizer and resolves one bit per trial.
- Presents the converted word to user logic with a start/busy/valid handshake.

Parameters:
- NBITS, 8, conversion resolution in bits; range 2..12.
- SAMPLE_CYC, 4, track-phase length in clocks; range 1..255.
- SETTLE_CYC, 4, clocks per trial from DAC update to decision, including the 2-flop sync latency; range 3..255.

Ports:
- wb_clk_i  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- start_i  input  1  conversion request, level-sampled in IDLE.
- cont_i  input  1  continuous mode: restart automatically after each result.
- abort_i  input  1  synchronous abort; returns to IDLE next cycle.
- cmp_i  input  1  raw comparator VOUT (asynchronous); 1 means VINP >= VINM.
- cmp_en_o  output  1  comparator/bias enable.
- sample_o  output  1  track/hold switch control; 1 = track.
- dac_o  output  NBITS  DAC code applied to VINM.
- busy_o  output  1  conversion in progress.
- data_o  output  NBITS  last completed result; holds until the next completion.
- valid_o  output  1  one-cycle pulse when data_o updates.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; dac_o=0; data_o=0; both sync flops 0.
- cmp_i passes through 2 flops (cmp_s). No other logic uses cmp_i directly.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE:
  - busy_o=0, cmp_en_o=0.
  - start_i=1 at a clock edge -> SAMPLE; cnt=SAMPLE_CYC-1.
- SAMPLE:
  - sample_o=1, cmp_en_o=1, busy_o=1, dac_o=0.
  - cnt=0 -> SETTLE with dac_o=1<<(NBITS-1), bitptr=NBITS-1, cnt=SETTLE_CYC-1.
  - Otherwise cnt decrements.
- SETTLE:
  - sample_o=0, cmp_en_o=1.
  - Holds dac_o for SETTLE_CYC cycles; cnt decrements; cnt=0 -> DECIDE.
- DECIDE (one cycle):
  - cmp_s=0 -> clear dac_o[bitptr]; cmp_s=1 -> keep it.
  - bitptr>0 -> set dac_o[bitptr-1], bitptr decrements, cnt=SETTLE_CYC-1, go to SETTLE.
  - bitptr=0 -> DONE.
- DONE (one cycle):
  - data_o<=dac_o; valid_o=1; busy_o=1.
  - cont_i=1 -> SAMPLE (cnt=SAMPLE_CYC-1).
  - Otherwise -> IDLE, with dac_o held.
- Latency: valid_o asserts exactly SAMPLE_CYC + NBITS*(SETTLE_CYC+1) + 1 clocks after the edge where start_i is accepted. Defaults give 4+8*5+1 = 45.
- start_i outside IDLE is ignored. No queuing.
- abort_i has priority over all transitions in any non-IDLE state:
  - Next state IDLE, dac_o=0, sample_o=0.
  - data_o unchanged; no valid_o.
  - abort_i in IDLE has no effect.
- abort_i and start_i high together in IDLE -> stays IDLE.
- cont_i is sampled only in DONE. Deasserting it mid-conversion finishes the current conversion, then idles.
- Reset mid-conversion: immediate return to reset values; no partial result is written.
- Codes are unsigned. Full-scale result is 2^NBITS-1; zero input gives 0.

Test Plan:
- Bench comparator model: cmp_i = (vin_code >= dac_o), applied with a 1-cycle skew. Defaults throughout.
- Single conversion, vin_code=0xA5, start_i one-cycle pulse:
  - data_o=0xA5 with valid_o exactly 45 clocks after the accept edge.
  - busy_o high 45 cycles; dac_o trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
- Boundaries: vin_code=0x00 -> data_o=0x00; vin_code=0xFF -> data_o=0xFF. No extra valid_o pulses.
- Continuous mode, cont_i=1, vin_code 0x3C then 0xC3 changed mid-run:
  - Back-to-back valid_o pulses 45 clocks apart.
  - Results 0x3C then 0xC3; sample_o re-asserts the cycle after each DONE.
- abort_i pulsed at clock 20 of a conversion:
  - IDLE next cycle, busy_o=0, dac_o=0.
  - data_o keeps its prior value; no valid_o.
  - A following start_i converts normally.
- resetb low for 3 cycles mid-SETTLE: all outputs 0 asynchronously. After release, start_i ignored while busy, then a fresh conversion yields the correct code.
